// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU data-side bridge.
//   state_e      : bridge FSM state encoding
//   BYTEEN_WORD  : full-word byte enable (only full-word peripheral writes allowed)
//   TMO_CYC_DEF  : default peripheral timeout in ACCESS cycles
//   WIN_W        : width of one window-table field (address width)
//   SLOT_W       : width of the slot index (up to 8 windows)
//   CNT_W        : width of the timeout counter (TMO_CYC up to 255)
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BYTEEN_WORD = 4'hF;
  localparam int         TMO_CYC_DEF = 16;
  localparam int         WIN_W       = 32;
  localparam int         SLOT_W      = 3;
  localparam int         CNT_W       = 8;

endpackage

// File: rtl/bridge_decode.sv
// Address window decoder (purely combinational).
//   addr     in   CPU byte address
//   any_hit  out  address falls inside at least one peripheral window
//   hit_idx  out  index of the lowest-numbered window that matches
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int                        N_SLV    = 3,
  parameter logic [N_SLV*WIN_W-1:0]    SLV_BASE = {32'h7F20, 32'h7F10, 32'h7F00},
  parameter logic [N_SLV*WIN_W-1:0]    SLV_LAST = {32'h7F23, 32'h7F1B, 32'h7F0B}
) (
  input  logic [WIN_W-1:0]  addr,
  output logic              any_hit,
  output logic [SLOT_W-1:0] hit_idx
);

  // Scan from the highest slot down so the lowest matching index is the
  // last one written and therefore wins on overlapping windows.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr >= SLV_BASE[i*WIN_W +: WIN_W]) && (addr <= SLV_LAST[i*WIN_W +: WIN_W])) begin
        any_hit = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/sys_bridge_n.sv
// CPU data-side bridge: routes accesses either to data memory (zero-wait,
// combinational) or to one of N_SLV peripheral windows (registered, with
// ack handshake and timeout).
//   clk, reset                         clock, synchronous active-high reset
//   cpu_req/addr/wdata/byteen          CPU access request
//   cpu_rdata/ready/err                CPU response (err pulses with ready)
//   dm_addr/wdata/byteen, dm_rdata     data-memory port
//   slv_sel/addr/wdata/we              registered peripheral request
//   slv_rdata, slv_ack                 packed peripheral responses
//   err_addr                           address of the last errored access
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int                     N_SLV    = 3,
  parameter logic [N_SLV*WIN_W-1:0] SLV_BASE = {32'h7F20, 32'h7F10, 32'h7F00},
  parameter logic [N_SLV*WIN_W-1:0] SLV_LAST = {32'h7F23, 32'h7F1B, 32'h7F0B},
  parameter int                     TMO_CYC  = TMO_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_byteen,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [31:0]            dm_addr,
  output logic [31:0]            dm_wdata,
  output logic [3:0]             dm_byteen,
  input  logic [31:0]            dm_rdata,
  output logic [N_SLV-1:0]       slv_sel,
  output logic [31:0]            slv_addr,
  output logic [31:0]            slv_wdata,
  output logic                   slv_we,
  input  logic [N_SLV*32-1:0]    slv_rdata,
  input  logic [N_SLV-1:0]       slv_ack,
  output logic [31:0]            err_addr
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SLOT_W-1:0]   idx_q;
  logic [N_SLV-1:0]    sel_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         err_addr_q;

  logic                any_hit;
  logic [SLOT_W-1:0]   hit_idx;
  logic [N_SLV-1:0]    sel_new;
  logic                ack_sel;
  logic [31:0]         rdata_sel;
  logic                byteen_ok;

  bridge_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_LAST (SLV_LAST)
  ) u_decode (
    .addr    (cpu_addr),
    .any_hit (any_hit),
    .hit_idx (hit_idx)
  );

  // One-hot select for the slot being entered, and the ack/read-data of the
  // slot latched for the transaction in flight (other slots are ignored).
  always_comb begin
    sel_new   = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      sel_new[i] = (hit_idx == SLOT_W'(i));
      if (idx_q == SLOT_W'(i)) begin
        ack_sel   = slv_ack[i];
        rdata_sel = slv_rdata[i*32 +: 32];
      end
    end
  end

  assign byteen_ok = (cpu_byteen == 4'h0) || (cpu_byteen == BYTEEN_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req && any_hit) begin
            if (byteen_ok) begin
              state_q <= ACCESS;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
              we_q    <= |cpu_byteen;
              idx_q   <= hit_idx;
              sel_q   <= sel_new;
              cnt_q   <= '0;
              err_q   <= 1'b0;
            end else begin
              // Partial-word peripheral access: reject without touching the bus.
              state_q    <= DONE;
              err_q      <= 1'b1;
              rdata_q    <= '0;
              err_addr_q <= cpu_addr;
            end
          end
        end
        ACCESS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (ack_sel) begin
            state_q <= DONE;
            rdata_q <= rdata_sel;
            err_q   <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
          end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
            state_q    <= DONE;
            rdata_q    <= '0;
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
            sel_q      <= '0;
            we_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  // Data memory sees every CPU access except those landing in a window.
  assign dm_addr   = cpu_addr;
  assign dm_wdata  = cpu_wdata;
  assign dm_byteen = any_hit ? 4'h0 : cpu_byteen;

  always_comb begin
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = dm_rdata;
    case (state_q)
      IDLE: cpu_ready = cpu_req && !any_hit;
      DONE: begin
        cpu_ready = 1'b1;
        cpu_err   = err_q;
        cpu_rdata = rdata_q;
      end
      default: begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
      end
    endcase
  end

  assign slv_sel   = sel_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_we    = we_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata;
  logic [2:0]  slv_sel;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic        slv_we;
  logic [95:0] slv_rdata;
  logic [2:0]  slv_ack;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  // results captured by run_acc
  int          n_acc;
  int          lat;
  logic        r_err;
  logic [31:0] r_rd;
  logic [2:0]  sel_seen;
  logic        we_seen;
  logic        dmbe_bad;
  logic [31:0] sa_seen;
  logic [31:0] sw_seen;
  int          pulses;

  sys_bridge_n dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_byteen  (dm_byteen),
    .dm_rdata   (dm_rdata),
    .slv_sel    (slv_sel),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_we     (slv_we),
    .slv_rdata  (slv_rdata),
    .slv_ack    (slv_ack),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One peripheral transaction. ack_m is driven during the ack_at-th ACCESS
  // cycle (ack_at < 0: never); bg_m is driven on all other cycles.
  task automatic run_acc(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input int ack_at, input logic [2:0] ack_m, input logic [2:0] bg_m,
                         input bit drop);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
    slv_ack = bg_m;
    n_acc = 0; lat = -1; r_err = 1'bx; r_rd = 32'hDEAD_BEEF;
    sel_seen = '0; we_seen = 1'b0; dmbe_bad = 1'b0; sa_seen = '0; sw_seen = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (dm_byteen != 4'h0) dmbe_bad = 1'b1;
      if (cpu_ready) begin
        lat = c; r_err = cpu_err; r_rd = cpu_rdata;
        break;
      end
      if (slv_sel != 3'b000) begin
        n_acc++;
        sel_seen |= slv_sel;
        we_seen  |= slv_we;
        if (n_acc == 1) begin sa_seen = slv_addr; sw_seen = slv_wdata; end
      end
      if (drop && n_acc == 1) cpu_req = 1'b0;
      slv_ack = (n_acc == ack_at && slv_sel != 3'b000) ? ack_m : bg_m;
    end
    cpu_req = 1'b0; slv_ack = 3'b000; cpu_byteen = 4'h0;
  endtask

  task automatic dm_check(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] rd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; cpu_byteen = be; dm_rdata = rd;
    #2;
    check_eq({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    check_eq({tag, "_rdata"}, cpu_rdata, rd);
    check_eq({tag, "_dmbe"}, 32'(dm_byteen), 32'(be));
    check_eq({tag, "_sel"}, 32'(slv_sel), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0; cpu_byteen = 4'h0;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
    dm_rdata = '0; slv_ack = '0;
    slv_rdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sel", 32'(slv_sel), 32'd0);
    check_eq("rst_we", 32'(slv_we), 32'd0);
    check_eq("rst_ready", 32'(cpu_ready), 32'd0);
    check_eq("rst_err_addr", err_addr, 32'd0);
    check_eq("rst_slv_addr", slv_addr, 32'd0);
    reset = 1'b0;

    // data-memory path, including window edges just outside
    dm_check("dm_rd", 32'h0000_1000, 4'h0, 32'h1234_5678);
    dm_check("dm_wr", 32'h0000_2000, 4'h5, 32'h0BAD_F00D);
    dm_check("dm_7f0c", 32'h0000_7F0C, 4'hF, 32'h5555_0000);
    dm_check("dm_7f24", 32'h0000_7F24, 4'h0, 32'h6666_0000);

    // full-word write, slot 0, ack on first ACCESS cycle
    run_acc(32'h7F04, 4'hF, 32'hA5A5_0001, 1, 3'b001, 3'b000, 1'b0);
    check_eq("wr_lat", 32'(lat), 32'd2);
    check_eq("wr_nacc", 32'(n_acc), 32'd1);
    check_eq("wr_sel", 32'(sel_seen), 32'b001);
    check_eq("wr_we", 32'(we_seen), 32'd1);
    check_eq("wr_err", 32'(r_err), 32'd0);
    check_eq("wr_dmbe", 32'(dmbe_bad), 32'd0);
    check_eq("wr_saddr", sa_seen, 32'h7F04);
    check_eq("wr_swdata", sw_seen, 32'hA5A5_0001);

    // read, slot 2 last address, ack on third ACCESS cycle
    run_acc(32'h7F23, 4'h0, 32'h0, 3, 3'b100, 3'b000, 1'b0);
    check_eq("rd2_lat", 32'(lat), 32'd4);
    check_eq("rd2_sel", 32'(sel_seen), 32'b100);
    check_eq("rd2_we", 32'(we_seen), 32'd0);
    check_eq("rd2_rdata", r_rd, 32'hCCCC_0002);
    check_eq("rd2_err", 32'(r_err), 32'd0);

    // timeout on slot 1; acks from other slots are ignored
    run_acc(32'h7F14, 4'h0, 32'h0, -1, 3'b000, 3'b101, 1'b0);
    check_eq("tmo_nacc", 32'(n_acc), 32'd16);
    check_eq("tmo_lat", 32'(lat), 32'd17);
    check_eq("tmo_sel", 32'(sel_seen), 32'b010);
    check_eq("tmo_err", 32'(r_err), 32'd1);
    check_eq("tmo_rdata", r_rd, 32'd0);
    check_eq("tmo_err_addr", err_addr, 32'h7F14);

    // partial write to a window is rejected
    run_acc(32'h7F20, 4'h3, 32'h1111_2222, -1, 3'b000, 3'b000, 1'b0);
    check_eq("part_lat", 32'(lat), 32'd1);
    check_eq("part_sel", 32'(sel_seen), 32'd0);
    check_eq("part_err", 32'(r_err), 32'd1);
    check_eq("part_err_addr", err_addr, 32'h7F20);

    // ack on the timeout cycle: ack wins
    run_acc(32'h7F10, 4'h0, 32'h0, 16, 3'b010, 3'b000, 1'b0);
    check_eq("race_lat", 32'(lat), 32'd17);
    check_eq("race_err", 32'(r_err), 32'd0);
    check_eq("race_rdata", r_rd, 32'hBBBB_0001);
    check_eq("race_err_addr", err_addr, 32'h7F20);

    // cpu_req dropped during ACCESS: transaction still completes
    run_acc(32'h7F0B, 4'h0, 32'h0, 2, 3'b001, 3'b000, 1'b1);
    check_eq("drop_lat", 32'(lat), 32'd3);
    check_eq("drop_rdata", r_rd, 32'hAAAA_0000);

    // reset during ACCESS
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h7F08; cpu_byteen = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rsta_sel_pre", 32'(slv_sel), 32'b001);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check_eq("rsta_sel", 32'(slv_sel), 32'd0);
    check_eq("rsta_ready", 32'(cpu_ready), 32'd0);
    check_eq("rsta_err_addr", err_addr, 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ready) pulses++;
    end
    check_eq("rsta_pulses", 32'(pulses), 32'd0);
    dm_check("rsta_dm", 32'h0000_3000, 4'h0, 32'h7777_0000);
    run_acc(32'h7F00, 4'hF, 32'h0000_00AB, 1, 3'b001, 3'b000, 1'b0);
    check_eq("rsta_next_lat", 32'(lat), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
